// File: rtl/align_rd_sched_if.sv
// align_rd_sched_if: bus between the alignment-FIFO read scheduler, the FIFO
// and the video-output side. The scheduler connects through the slave modport;
// whatever drives sync and FIFO status uses the master modport.
interface align_rd_sched_if #(
  parameter int LVL_W = 12
);
  logic             vs;
  logic [LVL_W-1:0] fifo_lvl;
  logic             fifo_afull;
  logic             fifo_rd_en;
  logic             line_start;
  logic             frame_start;
  logic             frame_active;
  logic             underflow;
  logic [15:0]      uf_count;

  modport master (
    output vs, fifo_lvl, fifo_afull,
    input  fifo_rd_en, line_start, frame_start, frame_active, underflow, uf_count
  );

  modport slave (
    input  vs, fifo_lvl, fifo_afull,
    output fifo_rd_en, line_start, frame_start, frame_active, underflow, uf_count
  );
endinterface

// File: rtl/align_rd_sched.sv
// align_rd_sched: read-side scheduler for the RGB565 alignment FIFO.
// After a vs rising edge it waits for enough buffered pixels, then issues
// H_DISP back-to-back reads per line followed by H_GAP idle cycles, for V_DISP
// lines. Markers are registered together with fifo_rd_en so they line up with it.
// Optional feature: define ALIGN_UF_STAT_EN to get a lifetime underflow counter
// on uf_count; otherwise uf_count reads as zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, nothing scheduled, waits for a frame start
// WAIT_FILL | line pending, waits for fifo_lvl >= FILL_TH or fifo_afull
// READ      | one read per cycle, pix_cnt 0..H_DISP-1
// GAP       | H_GAP idle cycles after a line
// DONE      | all V_DISP lines issued, frame_active low, waits for vs
module align_rd_sched #(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int H_GAP   = 370,
  parameter int FILL_TH = 1280,
  parameter int LVL_W   = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  align_rd_sched_if.slave bus
);

  localparam int PIX_W  = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int GAP_W  = (H_GAP > 1) ? $clog2(H_GAP) : 1;
  localparam int LINE_W = $clog2(V_DISP + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(H_DISP - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((H_GAP > 0) ? (H_GAP - 1) : 0);
  localparam logic [LINE_W-1:0] LINE_END = LINE_W'(V_DISP);
  localparam logic [LVL_W-1:0]  FILL_LVL = LVL_W'(FILL_TH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FILL = 3'd1,
    READ      = 3'd2,
    GAP       = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state_q;
  logic                vs_d1_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [LINE_W-1:0]   line_cnt_q;
  logic                rd_en_q;
  logic                line_start_q;
  logic                frame_start_q;
  logic                frame_active_q;
  logic                underflow_q;

  logic                frame_det;
  logic                fill_ok;
  logic                lvl_empty;
  logic [LINE_W-1:0]   line_inc;

  assign frame_det = bus.vs & ~vs_d1_q;
  // fifo_afull lets reads start early so the writer side never overflows.
  assign fill_ok   = (bus.fifo_lvl >= FILL_LVL) | bus.fifo_afull;
  assign lvl_empty = (bus.fifo_lvl == '0);
  assign line_inc  = (line_cnt_q == LINE_END) ? line_cnt_q : line_cnt_q + LINE_W'(1);

  // Scheduler FSM; all outputs are registered next to the state so they
  // change on the same edge as fifo_rd_en. A frame start overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      vs_d1_q        <= 1'b0;
      pix_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      line_cnt_q     <= '0;
      rd_en_q        <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_active_q <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      vs_d1_q       <= bus.vs;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (frame_det) begin
        state_q        <= WAIT_FILL;
        pix_cnt_q      <= '0;
        gap_cnt_q      <= '0;
        line_cnt_q     <= '0;
        rd_en_q        <= 1'b0;
        frame_active_q <= 1'b1;
        underflow_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
          end
          WAIT_FILL: begin
            if (fill_ok) begin
              state_q       <= READ;
              rd_en_q       <= 1'b1;
              line_start_q  <= 1'b1;
              frame_start_q <= (line_cnt_q == '0);
            end
          end
          READ: begin
            if (lvl_empty) underflow_q <= 1'b1;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_q  <= '0;
              line_cnt_q <= line_inc;
              if (H_GAP > 0) begin
                state_q <= GAP;
                rd_en_q <= 1'b0;
              end else if (line_inc == LINE_END) begin
                state_q        <= DONE;
                rd_en_q        <= 1'b0;
                frame_active_q <= 1'b0;
              end else if (fill_ok) begin
                // No gap configured: the next line starts without a bubble.
                state_q      <= READ;
                rd_en_q      <= 1'b1;
                line_start_q <= 1'b1;
              end else begin
                state_q <= WAIT_FILL;
                rd_en_q <= 1'b0;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            end
          end
          GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_q <= '0;
              if (line_cnt_q == LINE_END) begin
                state_q        <= DONE;
                frame_active_q <= 1'b0;
              end else if (fill_ok) begin
                // Fill check folded into the last gap cycle, so the gap is exactly H_GAP.
                state_q      <= READ;
                rd_en_q      <= 1'b1;
                line_start_q <= 1'b1;
              end else begin
                state_q <= WAIT_FILL;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rd_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ALIGN_UF_STAT_EN
  logic [15:0] uf_count_q;

  // Lifetime tally of reads issued against an empty FIFO; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_count_q <= 16'h0;
    end else if ((state_q == READ) && lvl_empty && (uf_count_q != 16'hFFFF)) begin
      uf_count_q <= uf_count_q + 16'd1;
    end
  end

  assign bus.uf_count = uf_count_q;
`else
  assign bus.uf_count = 16'h0;
`endif

  assign bus.fifo_rd_en   = rd_en_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_active = frame_active_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_align_rd_sched.sv
// tb_align_rd_sched: drives two schedulers (H_GAP=3 and H_GAP=0) with identical
// stimulus; directed scenarios check fixed timelines, a random phase checks both
// against a line/frame-level reference model.
module tb_align_rd_sched;
  localparam int H  = 8;
  localparam int V  = 2;
  localparam int TH = 4;
  localparam int LW = 12;

`ifdef ALIGN_UF_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  align_rd_sched_if #(.LVL_W(LW)) if3 ();
  align_rd_sched_if #(.LVL_W(LW)) if0 ();

  align_rd_sched #(.H_DISP(H), .V_DISP(V), .H_GAP(3), .FILL_TH(TH), .LVL_W(LW)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  align_rd_sched #(.H_DISP(H), .V_DISP(V), .H_GAP(0), .FILL_TH(TH), .LVL_W(LW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));

  // {rd_en, line_start, frame_start, frame_active, underflow}
  logic [4:0] f3, f0;
  assign f3 = {if3.fifo_rd_en, if3.line_start, if3.frame_start, if3.frame_active, if3.underflow};
  assign f0 = {if0.fifo_rd_en, if0.line_start, if0.frame_start, if0.frame_active, if0.underflow};

  // Reference model: tracks reads/gap cycles still owed in the current line and
  // lines finished in the frame; outputs describe the cycle after each edge.
  typedef struct packed {
    logic vs_prev;
    logic waiting;
    logic rd, ls, fs, act, uf;
    int   reads_left;
    int   gap_left;
    int   lines_done;
    int   ufc;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t s, int hgap, logic vs, int lvl, logic afull);
    logic fill = (lvl >= TH) || afull;
    logic line_over = 1'b0;
    logic start = 1'b0;
    s.ls = 1'b0;
    s.fs = 1'b0;
    if (s.reads_left > 0 && lvl == 0 && s.ufc < 65535) s.ufc++;
    if (vs && !s.vs_prev) begin
      s.vs_prev = vs; s.act = 1'b1; s.uf = 1'b0; s.lines_done = 0;
      s.reads_left = 0; s.gap_left = 0; s.waiting = 1'b1; s.rd = 1'b0;
      return s;
    end
    s.vs_prev = vs;
    if (s.reads_left > 0) begin
      if (lvl == 0) s.uf = 1'b1;
      s.reads_left--;
      if (s.reads_left == 0) begin
        s.lines_done++;
        s.gap_left = hgap;
        line_over = (hgap == 0);
      end
    end else if (s.gap_left > 0) begin
      s.gap_left--;
      line_over = (s.gap_left == 0);
    end else if (s.waiting && fill) begin
      s.waiting = 1'b0;
      start = 1'b1;
    end
    if (line_over) begin
      if (s.lines_done == V) s.act = 1'b0;
      else if (fill) start = 1'b1;
      else s.waiting = 1'b1;
    end
    if (start) begin
      s.reads_left = H;
      s.ls = 1'b1;
      s.fs = (s.lines_done == 0);
    end
    s.rd = (s.reads_left > 0);
    return s;
  endfunction

  mdl_t m3, m0;

  // Advance both reference models on every clock, cleared by reset like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3 <= '0;
      m0 <= '0;
    end else begin
      m3 <= mdl_step(m3, 3, if3.vs, int'(if3.fifo_lvl), if3.fifo_afull);
      m0 <= mdl_step(m0, 0, if0.vs, int'(if0.fifo_lvl), if0.fifo_afull);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input int l, input logic af);
    if3.vs = v;  if0.vs = v;
    if3.fifo_lvl = l[LW-1:0];  if0.fifo_lvl = l[LW-1:0];
    if3.fifo_afull = af;  if0.fifo_afull = af;
  endtask

  task automatic start_frame();
    if3.vs = 1'b0; if0.vs = 1'b0;
    tick();
    if3.vs = 1'b1; if0.vs = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 0, 1'b0);
    repeat (3) tick();
    checks++; if (f3 !== 5'b0) begin errors++; $display("FAIL reset_flags_g3: got %b want 00000", f3); end
    checks++; if (f0 !== 5'b0) begin errors++; $display("FAIL reset_flags_g0: got %b want 00000", f0); end
    checks++; if (if3.uf_count !== 16'h0) begin errors++; $display("FAIL reset_ufc_g3: got %0d want 0", if3.uf_count); end
    checks++; if (if0.uf_count !== 16'h0) begin errors++; $display("FAIL reset_ufc_g0: got %0d want 0", if0.uf_count); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (f3 !== 5'b0) begin errors++; $display("FAIL idle_after_reset_g3: got %b want 00000", f3); end
    checks++; if (f0 !== 5'b0) begin errors++; $display("FAIL idle_after_reset_g0: got %b want 00000", f0); end
  endtask

  // Full frame with plenty of data: gap-3 and gap-0 timelines sample by sample.
  task automatic test_frame();
    logic [4:0] e3, e0;
    set_in(1'b0, 16, 1'b0);
    start_frame();
    for (int k = 0; k < 30; k++) begin
      tick();
      e3 = {((k >= 1 && k < 1 + H) || (k >= 4 + H && k < 4 + 2 * H)),
            (k == 1 || k == 4 + H), (k == 1), (k < 7 + 2 * H), 1'b0};
      e0 = {(k >= 1 && k < 1 + 2 * H), (k == 1 || k == 1 + H), (k == 1), (k < 1 + 2 * H), 1'b0};
      checks++; if (f3 !== e3) begin errors++; $display("FAIL frame_g3 s%0d: got %b want %b", k, f3, e3); end
      checks++; if (f0 !== e0) begin errors++; $display("FAIL frame_g0 s%0d: got %b want %b", k, f0, e0); end
    end
  endtask

  task automatic test_fill();
    set_in(1'b1, 2, 1'b0);
    start_frame();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (f3 !== 5'b00010) begin errors++; $display("FAIL fill_wait_g3 s%0d: got %b want 00010", k, f3); end
    end
    set_in(1'b1, 4, 1'b0);
    tick();
    checks++; if (f3 !== 5'b11110) begin errors++; $display("FAIL fill_start_g3: got %b want 11110", f3); end
    checks++; if (f0 !== 5'b11110) begin errors++; $display("FAIL fill_start_g0: got %b want 11110", f0); end
    set_in(1'b1, 1, 1'b1);
    start_frame();
    tick();
    checks++; if (f3 !== 5'b00010) begin errors++; $display("FAIL afull_wait_g3: got %b want 00010", f3); end
    tick();
    checks++; if (f3 !== 5'b11110) begin errors++; $display("FAIL afull_start_g3: got %b want 11110", f3); end
    checks++; if (f0 !== 5'b11110) begin errors++; $display("FAIL afull_start_g0: got %b want 11110", f0); end
    set_in(1'b1, 16, 1'b0);
  endtask

  // vs rises while gap-3 unit is on line 1 pixel 5; gap-0 unit is already done.
  task automatic test_abort();
    start_frame();
    for (int k = 0; k <= 17; k++) begin
      tick();
      if (k == 3) begin if3.vs = 1'b0; if0.vs = 1'b0; end
    end
    checks++; if (f3 !== 5'b10010) begin errors++; $display("FAIL abort_pre_g3: got %b want 10010", f3); end
    checks++; if (f0 !== 5'b00000) begin errors++; $display("FAIL abort_pre_g0: got %b want 00000", f0); end
    if3.vs = 1'b1; if0.vs = 1'b1;
    tick();
    checks++; if (f3 !== 5'b00010) begin errors++; $display("FAIL abort_drop_g3: got %b want 00010", f3); end
    checks++; if (f0 !== 5'b00010) begin errors++; $display("FAIL abort_drop_g0: got %b want 00010", f0); end
    tick();
    checks++; if (f3 !== 5'b11110) begin errors++; $display("FAIL abort_restart_g3: got %b want 11110", f3); end
    checks++; if (f0 !== 5'b11110) begin errors++; $display("FAIL abort_restart_g0: got %b want 11110", f0); end
  endtask

  task automatic test_underflow();
    logic [15:0] exp_ufc;
    exp_ufc = STAT_EN ? 16'd3 : 16'd0;
    start_frame();
    tick();
    tick();
    checks++; if (f3 !== 5'b11110) begin errors++; $display("FAIL uf_pre_g3: got %b want 11110", f3); end
    set_in(1'b1, 0, 1'b0);
    tick();
    checks++; if (f3 !== 5'b10011) begin errors++; $display("FAIL uf_set_g3: got %b want 10011", f3); end
    checks++; if (f0 !== 5'b10011) begin errors++; $display("FAIL uf_set_g0: got %b want 10011", f0); end
    tick();
    tick();
    set_in(1'b1, 16, 1'b0);
    checks++; if (if3.uf_count !== exp_ufc) begin errors++; $display("FAIL uf_count_g3: got %0d want %0d", if3.uf_count, exp_ufc); end
    checks++; if (if0.uf_count !== exp_ufc) begin errors++; $display("FAIL uf_count_g0: got %0d want %0d", if0.uf_count, exp_ufc); end
    repeat (10) tick();
    checks++; if (f3[0] !== 1'b1) begin errors++; $display("FAIL uf_sticky_g3: got %b want 1", f3[0]); end
    checks++; if (f0[0] !== 1'b1) begin errors++; $display("FAIL uf_sticky_g0: got %b want 1", f0[0]); end
    start_frame();
    tick();
    checks++; if (f3 !== 5'b00010) begin errors++; $display("FAIL uf_clear_g3: got %b want 00010", f3); end
    checks++; if (f0 !== 5'b00010) begin errors++; $display("FAIL uf_clear_g0: got %b want 00010", f0); end
    checks++; if (if3.uf_count !== exp_ufc) begin errors++; $display("FAIL uf_count_keep_g3: got %0d want %0d", if3.uf_count, exp_ufc); end
  endtask

  task automatic test_reset_mid();
    start_frame();
    repeat (3) tick();
    checks++; if (f3 !== 5'b10010) begin errors++; $display("FAIL rst_pre_g3: got %b want 10010", f3); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (f3 !== 5'b0) begin errors++; $display("FAIL rst_async_g3: got %b want 00000", f3); end
    checks++; if (f0 !== 5'b0) begin errors++; $display("FAIL rst_async_g0: got %b want 00000", f0); end
    checks++; if (if3.uf_count !== 16'h0) begin errors++; $display("FAIL rst_async_ufc_g3: got %0d want 0", if3.uf_count); end
    set_in(1'b0, 16, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (f3 !== 5'b0) begin errors++; $display("FAIL rst_idle_g3 s%0d: got %b want 00000", k, f3); end
      checks++; if (f0 !== 5'b0) begin errors++; $display("FAIL rst_idle_g0 s%0d: got %b want 00000", k, f0); end
    end
    start_frame();
    tick();
    checks++; if (f3 !== 5'b00010) begin errors++; $display("FAIL rst_resume_wait_g3: got %b want 00010", f3); end
    tick();
    checks++; if (f3 !== 5'b11110) begin errors++; $display("FAIL rst_resume_read_g3: got %b want 11110", f3); end
  endtask

  task automatic test_random(input int n);
    logic [4:0]  e3, e0;
    logic [15:0] u3, u0;
    logic        v;
    int          r, l;
    v = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      e3 = {m3.rd, m3.ls, m3.fs, m3.act, m3.uf};
      e0 = {m0.rd, m0.ls, m0.fs, m0.act, m0.uf};
      u3 = STAT_EN ? m3.ufc[15:0] : 16'h0;
      u0 = STAT_EN ? m0.ufc[15:0] : 16'h0;
      checks++; if (f3 !== e3) begin errors++; $display("FAIL rand_flags_g3 c%0d: got %b want %b", c, f3, e3); end
      checks++; if (f0 !== e0) begin errors++; $display("FAIL rand_flags_g0 c%0d: got %b want %b", c, f0, e0); end
      checks++; if (if3.uf_count !== u3) begin errors++; $display("FAIL rand_ufc_g3 c%0d: got %0d want %0d", c, if3.uf_count, u3); end
      checks++; if (if0.uf_count !== u0) begin errors++; $display("FAIL rand_ufc_g0 c%0d: got %0d want %0d", c, if0.uf_count, u0); end
      if ($urandom_range(0, 59) == 0) v = ~v;
      r = $urandom_range(0, 9);
      if (r == 0)      l = 0;
      else if (r < 3)  l = $urandom_range(1, TH - 1);
      else             l = $urandom_range(TH, 4095);
      set_in(v, l, ($urandom_range(0, 19) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_fill();
    test_abort();
    test_underflow();
    test_reset_mid();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
